// File: rtl/poly94_video_pkg.sv
// Shared types and constants for the Poly94 video fetch path.
package poly94_video_pkg;

    localparam int SDRAM_ADDR_W   = 24;
    localparam int SDRAM_DATA_W   = 16;
    localparam int DEF_LINE_WORDS = 320;
    localparam int DEF_LINES      = 480;
    localparam int DEF_BURST_LEN  = 8;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_ACK   = 3'd2,
        FS_DONE  = 3'd3,
        FS_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/video_line_buffer.sv
// Two-bank scanline store: the write bank is filled by the fetcher, the read bank is
// scanned out through a registered read port so the array maps onto block RAM.
module video_line_buffer
    import poly94_video_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic                          wr_bank_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
    input  logic [SDRAM_DATA_W-1:0]       wr_data_i,
    input  logic                          rd_bank_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_idx_i,
    output logic [SDRAM_DATA_W-1:0]       rd_data_o
);

    localparam int IW    = $clog2(LINE_WORDS);
    localparam int DEPTH = 2 * LINE_WORDS;
    localparam int AW    = $clog2(DEPTH);

    logic [SDRAM_DATA_W-1:0] mem_q [DEPTH];
    logic [SDRAM_DATA_W-1:0] rd_data_q;
    logic [AW-1:0]           wr_addr_s;
    logic [AW-1:0]           rd_addr_s;
    logic                    rd_ok_s;

    function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [IW-1:0] idx);
        logic [AW-1:0] a;
        if (bank) begin
            a = AW'(LINE_WORDS) + AW'(idx);
        end else begin
            a = AW'(idx);
        end
        return a;
    endfunction

    assign wr_addr_s = bank_addr(wr_bank_i, wr_idx_i);
    assign rd_addr_s = bank_addr(rd_bank_i, rd_idx_i);
    // Indices past the end of a line read as zero rather than spilling into the other bank.
    assign rd_ok_s   = ({1'b0, rd_idx_i} < (IW + 1)'(LINE_WORDS));

    // Write port: one word per accepted SDRAM beat.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_s] <= wr_data_i;
        end
    end

    // Registered read port for scanout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= {SDRAM_DATA_W{1'b0}};
        end else if (rd_ok_s) begin
            rd_data_q <= mem_q[rd_addr_s];
        end else begin
            rd_data_q <= {SDRAM_DATA_W{1'b0}};
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_line_fetcher.sv
// Scanline prefetch engine: bursts the next line from SDRAM into the back bank of a
// double line buffer. Define VIDEO_FETCH_LINEDOUBLE_EN to show every fetched line twice.
module video_line_fetcher
    import poly94_video_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LINES      = DEF_LINES,
    parameter int STRIDE_X16 = LINE_WORDS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [SDRAM_ADDR_W-1:0]       fb_base_x16,
    input  logic                          frame_start_i,
    input  logic                          line_start_i,
    output logic                          sdram_rd,
    output logic [SDRAM_ADDR_W-1:0]       sdram_addr_x16,
    input  logic                          sdram_rdy,
    input  logic [SDRAM_DATA_W-1:0]       sdram_rdata,
    output logic                          sdram_ack,
    input  logic [$clog2(LINE_WORDS)-1:0] pix_addr_i,
    output logic [SDRAM_DATA_W-1:0]       pix_data_o,
    output logic                          underrun_o,
    output logic                          busy_o
);

    localparam int IW  = $clog2(LINE_WORDS);
    localparam int WCW = $clog2(LINE_WORDS + 1);
    localparam int LCW = $clog2(LINES + 1);
    localparam int BCW = $clog2(BURST_LEN + 1);

    fetch_state_e            state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [SDRAM_ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [LCW-1:0]          line_cnt_q, line_cnt_d;
    logic [WCW-1:0]          word_cnt_q, word_cnt_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic                    front_q, front_d;
    logic                    pend_q, pend_d;
    logic                    restart_q, restart_d;
    logic                    rd_q, rd_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic                    underrun_q, underrun_d;
    logic                    swap_s, event_s, beat_last_s, we_s;

`ifdef VIDEO_FETCH_LINEDOUBLE_EN
    localparam int FETCH_LINES = LINES / 2;
    logic phase_q, phase_d;
    // Only the first pulse of each displayed pair swaps banks.
    assign swap_s = line_start_i && !frame_start_i && !phase_q;
`else
    localparam int FETCH_LINES = LINES;
    assign swap_s = line_start_i && !frame_start_i;
`endif

    assign event_s     = frame_start_i || swap_s;
    assign beat_last_s = (beat_q == BCW'(BURST_LEN - 1));
    assign we_s        = (state_q == FS_REQ) && sdram_rdy;

    // Fetch sequencing and frame/line event handling.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        burst_addr_d = burst_addr_q;
        line_cnt_d   = line_cnt_q;
        word_cnt_d   = word_cnt_q;
        beat_d       = beat_q;
        front_d      = front_q;
        pend_d       = pend_q;
        restart_d    = restart_q;
        underrun_d   = 1'b0;
`ifdef VIDEO_FETCH_LINEDOUBLE_EN
        phase_d      = phase_q;
        if (frame_start_i) begin
            phase_d = 1'b0;
        end else if (line_start_i) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end
`endif

        case (state_q)
            FS_IDLE: begin
                if (pend_q && enable_i) begin
                    state_d = FS_REQ;
                end else begin
                    state_d = FS_IDLE;
                end
            end
            FS_REQ, FS_DRAIN: begin
                if (sdram_rdy) begin
                    if (state_q == FS_REQ) begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                    if (beat_last_s) begin
                        beat_d  = {BCW{1'b0}};
                        state_d = FS_ACK;
                    end else begin
                        beat_d  = beat_q + BCW'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            FS_ACK: begin
                // After a drain the burst address already points at the restarted line.
                if (!restart_q) begin
                    burst_addr_d = burst_addr_q + SDRAM_ADDR_W'(BURST_LEN);
                end else begin
                    burst_addr_d = burst_addr_q;
                end
                restart_d = 1'b0;
                if (word_cnt_q == WCW'(LINE_WORDS)) begin
                    state_d = FS_DONE;
                    pend_d  = 1'b0;
                end else if (pend_q && enable_i) begin
                    state_d = FS_REQ;
                end else begin
                    state_d = FS_IDLE;
                end
            end
            FS_DONE: begin
                state_d = FS_DONE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        if (event_s) begin
            if (frame_start_i) begin
                line_addr_d = fb_base_x16;
                line_cnt_d  = {LCW{1'b0}};
                front_d     = 1'b1;
                underrun_d  = 1'b0;
            end else begin
                line_addr_d = line_addr_q + SDRAM_ADDR_W'(STRIDE_X16);
                line_cnt_d  = (line_cnt_q < LCW'(FETCH_LINES)) ? line_cnt_q + LCW'(1) : line_cnt_q;
                front_d     = ~front_q;
                underrun_d  = (state_q != FS_DONE);
            end
            word_cnt_d   = {WCW{1'b0}};
            burst_addr_d = line_addr_d;
            pend_d       = (line_cnt_d < LCW'(FETCH_LINES));
            if (state_q == FS_REQ || state_q == FS_DRAIN) begin
                restart_d = 1'b1;
                state_d   = (sdram_rdy && beat_last_s) ? FS_ACK : FS_DRAIN;
            end else begin
                restart_d = 1'b0;
                state_d   = (pend_d && enable_i) ? FS_REQ : FS_IDLE;
            end
        end else begin
            line_addr_d = line_addr_d;
        end

        rd_d   = (state_d == FS_REQ) || (state_d == FS_DRAIN);
        ack_d  = (state_d == FS_ACK);
        busy_d = rd_d || ack_d;
        addr_d = (state_d == FS_REQ) ? burst_addr_d : addr_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FS_IDLE;
            line_addr_q  <= {SDRAM_ADDR_W{1'b0}};
            burst_addr_q <= {SDRAM_ADDR_W{1'b0}};
            addr_q       <= {SDRAM_ADDR_W{1'b0}};
            line_cnt_q   <= {LCW{1'b0}};
            word_cnt_q   <= {WCW{1'b0}};
            beat_q       <= {BCW{1'b0}};
            front_q      <= 1'b0;
            pend_q       <= 1'b0;
            restart_q    <= 1'b0;
            rd_q         <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            burst_addr_q <= burst_addr_d;
            addr_q       <= addr_d;
            line_cnt_q   <= line_cnt_d;
            word_cnt_q   <= word_cnt_d;
            beat_q       <= beat_d;
            front_q      <= front_d;
            pend_q       <= pend_d;
            restart_q    <= restart_d;
            rd_q         <= rd_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef VIDEO_FETCH_LINEDOUBLE_EN
    // Line-pair phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    video_line_buffer #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (we_s),
        .wr_bank_i  (~front_q),
        .wr_idx_i   (word_cnt_q[IW-1:0]),
        .wr_data_i  (sdram_rdata),
        .rd_bank_i  (front_q),
        .rd_idx_i   (pix_addr_i),
        .rd_data_o  (pix_data_o)
    );

    assign sdram_rd       = rd_q;
    assign sdram_ack      = ack_q;
    assign sdram_addr_x16 = addr_q;
    assign underrun_o     = underrun_q;
    assign busy_o         = busy_q;

endmodule

// File: doc/video_line_fetcher.md
# video_line_fetcher

Scanline prefetch engine for the Poly94 framebuffer. It is the video requester on the SDRAM arbiter's video port and issues burst reads of one scanline ahead of the beam into a two-bank line buffer. Scanout reads pixels from the front bank while the next line fills the back bank. Underruns are flagged, never stalled.

## Interface
Parameters:
- `LINE_WORDS`, 320: 16-bit words fetched per scanline. Must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 8: words per SDRAM burst (one arbiter grant).
- `LINES`, 480: visible lines per frame.
- `STRIDE_X16`, `LINE_WORDS`: address increment between lines, in 16-bit words.

Ports:
- `clk_i`  in  1  system clock; the block uses this one clock only.
- `rst_i`  in  1  reset, synchronous, active-high.
- `enable_i`  in  1  fetch enable. When low, no new burst is started.
- `fb_base_x16`  in  24  framebuffer base address; latched on `frame_start_i`.
- `frame_start_i`  in  1  one-cycle pulse, at least one line time before line 0.
- `line_start_i`  in  1  one-cycle pulse at the start of each visible line.
- `sdram_rd`  out  1  burst read request to the arbiter's video port.
- `sdram_addr_x16`  out  24  burst start address.
- `sdram_rdy`  in  1  read data word valid.
- `sdram_rdata`  in  16  read data word.
- `sdram_ack`  out  1  one-cycle burst release.
- `pix_addr_i`  in  $clog2(LINE_WORDS)  word index into the front bank.
- `pix_data_o`  out  16  front-bank word.
- `underrun_o`  out  1  one-cycle pulse: a line swap happened before its fetch completed.
- `busy_o`  out  1  a line fetch is in progress.

## Operation
- State machine: IDLE → REQ → ACK → (REQ | DONE), plus DRAIN.
  - **IDLE:** no fetch pending.
  - **REQ:** `sdram_rd`=1, address stable. Each cycle with `sdram_rdy`=1 writes `sdram_rdata` to back bank index `word_cnt`, then increments `word_cnt`. After the `BURST_LEN`-th word, go to ACK.
  - **ACK:** `sdram_rd`=0, `sdram_ack`=1 for exactly one cycle. `burst_addr` += `BURST_LEN`. If `word_cnt`==`LINE_WORDS`, go to DONE. Otherwise go to REQ if `enable_i`, else IDLE (resumes at the same point when `enable_i` rises).
  - **DONE:** back bank complete; wait for `line_start_i`.
  - **DRAIN:** finish the current burst (words are discarded, ack is still issued), then restart from the pending event.
- `frame_start_i`:
  - Latch `fb_base_x16` into `line_addr`; set `line_cnt`=0; clear `word_cnt`.
  - Start fetching line 0 into bank 0; `front`=1.
  - If it arrives mid-burst, enter DRAIN first.
- `line_start_i`:
  - Set `front` to the other bank; the back bank becomes the new front.
  - If the fetch was not in DONE, pulse `underrun_o`; if mid-burst, DRAIN.
  - Then set `line_addr` += `STRIDE_X16` and `line_cnt`++.
  - If `line_cnt` < `LINES`, fetch the next line into the new back bank; otherwise go to IDLE until the next `frame_start_i`.
- Address arithmetic is modulo 2^24. Wrap past 0xFFFFFF is silent.
- `frame_start_i` and `line_start_i` in the same cycle: `frame_start_i` wins; `line_start_i` is ignored.
- `sdram_rdy` outside REQ is ignored.
- `rst_i` mid-burst: all outputs return to reset values next cycle. The arbiter shares `rst_i`, so no ack is owed.
- Reset values: `sdram_rd`=0, `sdram_ack`=0, `sdram_addr_x16`=0, `pix_data_o`=0, `underrun_o`=0, `busy_o`=0, `front`=0, state IDLE.

## Timing
- Request latency:
  - `sdram_rd` rises the cycle after `frame_start_i`, or after `line_start_i` when the fetch is ready.
  - Between bursts, `sdram_rd` is low for exactly one cycle (ACK).
- `sdram_addr_x16` is registered and stable for the whole REQ state.
- Data words are written on the `sdram_rdy` cycle. The first `rdy` may arrive any number of cycles after `rd` rises; arbiter wait states are absorbed.
- `pix_data_o` is registered: data for `pix_addr_i` appears 1 cycle later.
- A bank swap takes effect for reads issued the cycle after `line_start_i`.
- `underrun_o` is asserted the cycle after `line_start_i`.
- `busy_o` is high from the first `sdram_rd` of a line until DONE or IDLE.

## Configuration
- `VIDEO_FETCH_LINEDOUBLE_EN`:
  - **Defined:** only every second `line_start_i` swaps banks and advances `line_addr`, so each fetched line is shown twice. `line_cnt` counts fetched lines, and fetching stops at `LINES`/2. Underrun is checked only on swapping pulses.
  - **Undefined:** every `line_start_i` swaps and advances, as described above.

## Structure
- Package `poly94_video_pkg` holds:
  - the fetch state enum;
  - `SDRAM_ADDR_W`=24 and `SDRAM_DATA_W`=16;
  - default `LINE_WORDS`/`LINES`.
- Sub-module `video_line_buffer`: two banks of `LINE_WORDS`×16 in simple dual-port RAM.
  - Write port: fetcher, selected by `~front`.
  - Read port: registered, selected by `front`.
  - Infers block RAM.

## Test plan
- **Basic line fetch:** base 0x000100, `LINE_WORDS`=16, `BURST_LEN`=8, arbiter model with `rdy` every cycle after 3 wait states.
  - Expect two bursts at 0x000100 and 0x000108, each followed by a one-cycle ack.
  - Expect `busy_o` to fall, then front-bank reads return the model data after `line_start_i`.
- **Underrun:** stall `rdy` so only 8 of 16 words arrive before `line_start_i`.
  - Expect `underrun_o` 1-cycle pulse, the burst completed and acked, and the next fetch at base+`STRIDE_X16`.
- **Frame end and restart:** `LINES`=2.
  - After the second `line_start_i`, expect no `sdram_rd`.
  - `frame_start_i` with base 0xFFFFF8 → addresses 0xFFFFF8, then 0x000000 (wrap).
- **Simultaneous events:** `frame_start_i` and `line_start_i` in the same cycle mid-burst.
  - Expect drain with ack, no `underrun_o`, and refetch from the new base into bank 0.
- **Enable and reset:** drop `enable_i` mid-line → the current burst acks, then `rd` stays low; raise `enable_i` → resumes at the next burst address. Assert `rst_i` during REQ → `sdram_rd`=0 the next cycle and all outputs at reset values.
- **`VIDEO_FETCH_LINEDOUBLE_EN` defined:** 4 `line_start_i` pulses → exactly 2 line fetches, with swaps on pulses 1 and 3.
